// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port (nWr/Din/Full)
//            between NREQ producers, granting bursts of up to MaxBurst words.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int Bsize    = 8,
    parameter int MaxBurst = 4
) (
    input  logic                  Clk,
    input  logic                  nRst,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*Bsize-1:0] ReqData,
    output logic [NREQ-1:0]       Ack,
    output logic [NREQ-1:0]       Grant,
    output logic                  nWr,
    output logic [Bsize-1:0]      Din,
    input  logic                  Full,
    output logic                  Busy
);

    localparam int              c_PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW-1:0] c_LAST_IDX  = c_PW'(NREQ - 1);
    localparam logic [c_PW-1:0] c_ONE       = c_PW'(1);
    localparam logic [c_PW:0]   c_NREQ_EXT  = (c_PW + 1)'(NREQ);
    localparam logic [7:0]      c_LAST_BEAT = 8'(MaxBurst - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_owner;
    logic [c_PW-1:0] r_ptr;
    logic [7:0]      r_burst_cnt;

    logic [Bsize-1:0] w_slices [NREQ];
    logic [c_PW-1:0]  w_sel;
    logic [c_PW:0]    w_idx;
    logic [c_PW-1:0]  w_owner_next;
    logic             w_busy;
    logic             w_owner_req;
    logic             w_xfer;
    logic             w_release;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign w_slices[i] = ReqData[i*Bsize +: Bsize];
    end

    // Descending scan so the requester closest to r_ptr (smallest offset) wins.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (c_PW + 1)'(k);
            if (w_idx >= c_NREQ_EXT) begin
                w_idx = w_idx - c_NREQ_EXT;
            end
            if (Req[w_idx[c_PW-1:0]]) begin
                w_sel = w_idx[c_PW-1:0];
            end
        end
    end

    assign w_busy       = (r_state == S_BURST);
    assign w_owner_req  = Req[r_owner];
    assign w_xfer       = w_busy & w_owner_req & ~Full;
    assign w_release    = w_busy & (~w_owner_req | (w_xfer & (r_burst_cnt == c_LAST_BEAT)));
    assign w_owner_next = (r_owner == c_LAST_IDX) ? '0 : r_owner + c_ONE;

    // Outputs decode directly from reset-cleared state so nWr rises with nRst.
    always_comb begin
        Grant = '0;
        Ack   = '0;
        if (w_busy) begin
            Grant[r_owner] = 1'b1;
        end
        if (w_xfer) begin
            Ack[r_owner] = 1'b1;
        end
    end

    assign Busy = w_busy;
    assign nWr  = ~w_xfer;
    assign Din  = w_xfer ? w_slices[r_owner] : '0;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|Req) begin
                        r_owner     <= w_sel;
                        r_burst_cnt <= '0;
                        r_state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_release) begin
                        r_state     <= S_IDLE;
                        r_ptr       <= w_owner_next;
                        r_burst_cnt <= '0;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's FIFO (nWr/Din/Full interface) between NREQ producers.
It sits in the FIFO write-clock domain. It grants one producer at a time for a burst of up to MaxBurst words. Each accepted word is steered onto Din with nWr driven low, and the arbiter stalls while Full is high.
A rotating priority pointer guarantees every producer a grant within NREQ arbitration rounds.

Parameters:
NREQ, 4, number of producers (2..16)
Bsize, 8, data width; must equal the FIFO Bsize
MaxBurst, 4, maximum words transferred per grant (1..255)

Ports:
Clk  input  1  write clock; the same clock as the FIFO Wr_Clk
nRst  input  1  asynchronous active-low reset
Req  input  NREQ  per-producer write request, level; bit i high = producer i has a word on ReqData slice i
ReqData  input  NREQ*Bsize  producer data; slice i = ReqData[i*Bsize +: Bsize]
Ack  output  NREQ  one-hot pulse; word of producer i accepted this cycle
Grant  output  NREQ  one-hot current owner; all zero when no owner
nWr  output  1  FIFO write strobe, active low
Din  output  Bsize  FIFO write data
Full  input  1  FIFO full flag
Busy  output  1  high while state is BURST

Behaviour:
- Clocking and reset:
  - Single clock.
  - Asynchronous active-low reset (nRst), released synchronously by the integrating level.
- States:
  - IDLE (arbitrate).
  - BURST (owner holds the port).
- Registers:
  - state
  - Owner (log2 NREQ bits)
  - Ptr (priority pointer)
  - BurstCnt (8 bits)
- Reset values:
  - state=IDLE, Owner=0, Ptr=0, BurstCnt=0.
  - Outputs: Grant=0, Ack=0, nWr=1, Din=0, Busy=0.
- IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise select the first i with Req[i]=1, searching Ptr, Ptr+1, ..., wrapping modulo NREQ.
  - Owner<=i, BurstCnt<=0, go to BURST.
  - No write is issued in the IDLE cycle, so arbitration costs one cycle.
- BURST:
  - Grant = onehot(Owner). Busy=1.
  - Xfer = Req[Owner] & ~Full (combinational).
  - nWr = ~Xfer. Din = ReqData slice Owner when Xfer, else 0.
  - Ack[Owner] = Xfer; all other Ack bits are 0.
  - On Xfer: BurstCnt <= BurstCnt+1.
  - Release when Req[Owner]=0, or when Xfer occurs with BurstCnt==MaxBurst-1 (the last word is still written that cycle).
  - On release: state<=IDLE, Ptr<=(Owner+1) mod NREQ, BurstCnt<=0.
- Full handling:
  - While Full=1 in BURST: no Xfer, nWr=1, BurstCnt holds, owner retained.
  - Full is never a release cause.
- Producer contract:
  - A producer holds ReqData stable while Req is high until Ack.
  - Req may drop only in a cycle without Ack on that cycle's word, or after Ack.
  - The arbiter never drops a word it has acked.
- Simultaneous events:
  - Requests from non-owners are ignored until the owner releases.
  - A requester deasserting in the same cycle it would be selected in IDLE does not win, because selection uses current Req.
- Fairness:
  - After release, the previous owner has lowest priority.
  - Worst-case wait for a requester = (NREQ-1)*(MaxBurst+1) cycles plus Full stall time.
- Reset mid-burst:
  - Asserting nRst immediately forces the reset values.
  - nWr goes high asynchronously, so no partial write reaches the FIFO.
  - Ptr returns to 0.
- Width rule:
  - Ptr+1 wraps at NREQ, not at a power of two.
  - BurstCnt compare uses MaxBurst-1 zero-extended to 8 bits.

Test Plan:
- Reset, then Req=4'b0001, data 0xA5 held, Full=0 -> Busy from cycle 2. nWr low for 4 consecutive cycles with Din=0xA5 and Ack=4'b0001, then 1 IDLE cycle, then the next 4-word burst.
- Req=4'b1111, Full=0 for 40 cycles -> grants rotate 0,1,2,3,0. Each burst is 4 words; exactly 32 Ack pulses total, 8 per producer.
- Owner 2 in BURST after 2 words, Full=1 for 5 cycles -> nWr=1, Ack=0, Grant=4'b0100 held. After Full drops, 2 more words, then release; Ptr=3.
- Req=4'b0101, Ptr=3 -> producer 0 granted first (wrap), then producer 2.
- Owner 1 drops Req after 1 word -> release next edge; Ptr=2; 1 word written, no extra nWr pulse.
- nRst low mid-burst with nWr=0 -> nWr=1, Grant=0, Ack=0 asynchronously. After release, Req=4'b1000 is granted within 2 cycles; Ptr restarts at 0.
